cntl_multicycle: RTL and testbench

Control unit for the multi-cycle RV32I core. It is a Moore FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. From the current state and the instruction-register contents (`inst`), it drives the datapath:
- memory selects and enables
- register-file write
- ALU operand, operation and result-routing selects
- immediate field and extension controls

---
 rtl/cntl_mc_pkg.sv | 64 ++++++
 rtl/imm_decode.sv | 47 ++++
 rtl/cntl_multicycle.sv | 176 +++++++++++++++++
 tb/tb_cntl_multicycle.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cntl_mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit:
// FSM states, opcodes, ALU codes and datapath select codes.
package cntl_mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_PASSB = 5'b11111;
  localparam logic [1:0] ALU_BR    = 2'b10;

  localparam logic [1:0] OP2_RS2  = 2'b00;
  localparam logic [1:0] OP2_IMM  = 2'b01;
  localparam logic [1:0] OP2_FOUR = 2'b10;

  localparam logic [1:0] DMX_OUT  = 2'b00;
  localparam logic [1:0] DMX_ADDR = 2'b01;
  localparam logic [1:0] DMX_PC   = 2'b10;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_U    = 2'b10;
  localparam logic [1:0] EXT_BJ   = 2'b11;

  typedef struct packed {
    logic       mem_sz_ex_sel;
    logic       mem_sel;
    logic [1:0] mem_size;
    logic       pc_update;
    logic       load_ir;
    logic       load_mdr;
    logic       mem_wr_en;
    logic       reg_file_wr_en;
    logic       wr_reg_mux_sel;
    logic       op1_sel;
    logic [1:0] op2_sel;
    logic [1:0] alu_demux;
    logic [4:0] alu_ctrl;
  } ctrl_t;

  function automatic logic is_legal(input logic [6:0] opc);
    return opc == OPC_LUI   || opc == OPC_AUIPC ||
           opc == OPC_JAL   || opc == OPC_JALR  ||
           opc == OPC_BRANCH|| opc == OPC_LOAD  ||
           opc == OPC_STORE || opc == OPC_OPIMM ||
           opc == OPC_OP;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Extracts the raw immediate field and its extension controls
// from the instruction format implied by the opcode.
module imm_decode
  import cntl_mc_pkg::*;
(
  input  logic [31:0] inst,
  output logic [19:0] imm,
  output logic        sz_ex_sel,
  output logic [1:0]  sz_ex_mode
);

  logic [6:0] opc;
  assign opc = inst[6:0];

  always_comb begin
    imm        = '0;
    sz_ex_sel  = 1'b0;
    sz_ex_mode = EXT_SIGN;
    unique case (1'b1)
      (opc == OPC_LOAD) || (opc == OPC_OPIMM) ||
      (opc == OPC_JALR): begin
        imm = {8'b0, inst[31:20]};
      end
      (opc == OPC_STORE): begin
        imm = {8'b0, inst[31:25], inst[11:7]};
      end
      (opc == OPC_BRANCH): begin
        imm = {8'b0, inst[31], inst[7],
               inst[30:25], inst[11:8]};
        sz_ex_mode = EXT_BJ;
      end
      (opc == OPC_LUI) || (opc == OPC_AUIPC): begin
        imm        = inst[31:12];
        sz_ex_sel  = 1'b1;
        sz_ex_mode = EXT_U;
      end
      (opc == OPC_JAL): begin
        imm = {inst[31], inst[19:12],
               inst[20], inst[30:21]};
        sz_ex_sel  = 1'b1;
        sz_ex_mode = EXT_BJ;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cntl_multicycle.sv
// Moore control FSM for the multi-cycle RV32I core:
// FETCH -> DECODE -> EXEC -> [MEM] -> WB.
module cntl_multicycle
  import cntl_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        bcond,
  output logic        sz_ex_sel,
  output logic [1:0]  sz_ex_mode,
  output logic        mem_sz_ex_sel,
  output logic [19:0] imm,
  output logic        mem_sel,
  output logic [1:0]  mem_size,
  output logic        pc_update,
  output logic        load_ir,
  output logic        load_mdr,
  output logic        mem_wr_en,
  output logic        reg_file_wr_en,
  output logic        wr_reg_mux_sel,
  output logic        op1_sel,
  output logic [1:0]  op2_sel,
  output logic [1:0]  alu_demux,
  output logic [4:0]  alu_ctrl
);

  state_t      state, state_n;
  logic        br_taken;
  ctrl_t       c;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [19:0] dec_imm;
  logic        dec_sel;
  logic [1:0]  dec_mode;

  logic is_op, is_opimm, is_lui, is_auipc;
  logic is_jal, is_jalr, is_br, is_ld, is_st;

  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign is_op    = opc == OPC_OP;
  assign is_opimm = opc == OPC_OPIMM;
  assign is_lui   = opc == OPC_LUI;
  assign is_auipc = opc == OPC_AUIPC;
  assign is_jal   = opc == OPC_JAL;
  assign is_jalr  = opc == OPC_JALR;
  assign is_br    = opc == OPC_BRANCH;
  assign is_ld    = opc == OPC_LOAD;
  assign is_st    = opc == OPC_STORE;

  imm_decode u_imm (
    .inst       (inst),
    .imm        (dec_imm),
    .sz_ex_sel  (dec_sel),
    .sz_ex_mode (dec_mode)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      br_taken <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_EXEC) br_taken <= bcond;
    end
  end

  always_comb begin
    c       = '0;
    state_n = S_FETCH;
    unique case (state)
      S_FETCH: begin
        c.mem_size = 2'b10;
        c.load_ir  = 1'b1;
        state_n    = S_DECODE;
      end
      S_DECODE: begin
        state_n = is_legal(opc) ? S_EXEC : S_WB;
      end
      S_EXEC: begin
        c.alu_demux = DMX_OUT;
        c.alu_ctrl  = ALU_ADD;
        unique case (1'b1)
          is_op: begin
            c.op2_sel  = OP2_RS2;
            c.alu_ctrl = {1'b0, inst[30], f3};
          end
          is_opimm: begin
            c.op2_sel  = OP2_IMM;
            c.alu_ctrl = {1'b0, (f3 == 3'b101) & inst[30], f3};
          end
          is_lui: begin
            c.op2_sel  = OP2_IMM;
            c.alu_ctrl = ALU_PASSB;
          end
          is_auipc: begin
            c.op1_sel = 1'b1;
            c.op2_sel = OP2_IMM;
          end
          is_jal || is_jalr: begin
            c.op1_sel = 1'b1;
            c.op2_sel = OP2_FOUR;
          end
          is_ld || is_st: begin
            c.op2_sel   = OP2_IMM;
            c.alu_demux = DMX_ADDR;
          end
          is_br: begin
            c.op2_sel  = OP2_RS2;
            c.alu_ctrl = {ALU_BR, f3};
          end
          default: ;
        endcase
        state_n = (is_ld || is_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        c.mem_sel  = 1'b1;
        c.mem_size = f3[1:0];
        if (is_ld) begin
          c.load_mdr      = 1'b1;
          c.mem_sz_ex_sel = ~f3[2];
        end
        if (is_st) c.mem_wr_en = 1'b1;
        state_n = S_WB;
      end
      S_WB: begin
        c.pc_update = 1'b1;
        c.alu_demux = DMX_PC;
        c.alu_ctrl  = ALU_ADD;
        c.op1_sel   = 1'b1;
        c.op2_sel   = OP2_FOUR;
        if (is_jal || (is_br && br_taken)) begin
          c.op2_sel = OP2_IMM;
        end
        if (is_jalr) begin
          c.op1_sel = 1'b0;
          c.op2_sel = OP2_IMM;
        end
        if (is_op || is_opimm || is_lui ||
            is_auipc || is_jal || is_jalr) begin
          c.reg_file_wr_en = 1'b1;
        end
        if (is_ld) begin
          c.reg_file_wr_en = 1'b1;
          c.wr_reg_mux_sel = 1'b1;
        end
        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
    // reset quiets every control line, including any write enable
    if (rst) c = '0;
  end

  logic imm_vld;
  assign imm_vld = !rst && (state != S_FETCH);

  assign imm            = imm_vld ? dec_imm  : '0;
  assign sz_ex_sel      = imm_vld ? dec_sel  : 1'b0;
  assign sz_ex_mode     = imm_vld ? dec_mode : 2'b00;
  assign mem_sz_ex_sel  = c.mem_sz_ex_sel;
  assign mem_sel        = c.mem_sel;
  assign mem_size       = c.mem_size;
  assign pc_update      = c.pc_update;
  assign load_ir        = c.load_ir;
  assign load_mdr       = c.load_mdr;
  assign mem_wr_en      = c.mem_wr_en;
  assign reg_file_wr_en = c.reg_file_wr_en;
  assign wr_reg_mux_sel = c.wr_reg_mux_sel;
  assign op1_sel        = c.op1_sel;
  assign op2_sel        = c.op2_sel;
  assign alu_demux      = c.alu_demux;
  assign alu_ctrl       = c.alu_ctrl;

endmodule

// File: tb/tb_cntl_multicycle.sv
// Scoreboard bench for cntl_multicycle: per-cycle expected control
// vectors are queued as stimulus is driven and checked mid-cycle.
module tb_cntl_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = '0;
  logic        bcond = 1'b0;

  logic        sz_ex_sel, mem_sz_ex_sel, mem_sel;
  logic        pc_update, load_ir, load_mdr, mem_wr_en;
  logic        reg_file_wr_en, wr_reg_mux_sel, op1_sel;
  logic [1:0]  sz_ex_mode, mem_size, op2_sel, alu_demux;
  logic [19:0] imm;
  logic [4:0]  alu_ctrl;

  cntl_multicycle dut (
    .clk            (clk),
    .rst            (rst),
    .inst           (inst),
    .bcond          (bcond),
    .sz_ex_sel      (sz_ex_sel),
    .sz_ex_mode     (sz_ex_mode),
    .mem_sz_ex_sel  (mem_sz_ex_sel),
    .imm            (imm),
    .mem_sel        (mem_sel),
    .mem_size       (mem_size),
    .pc_update      (pc_update),
    .load_ir        (load_ir),
    .load_mdr       (load_mdr),
    .mem_wr_en      (mem_wr_en),
    .reg_file_wr_en (reg_file_wr_en),
    .wr_reg_mux_sel (wr_reg_mux_sel),
    .op1_sel        (op1_sel),
    .op2_sel        (op2_sel),
    .alu_demux      (alu_demux),
    .alu_ctrl       (alu_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sz_ex_sel;
    logic [1:0]  sz_ex_mode;
    logic        mem_sz_ex_sel;
    logic [19:0] imm;
    logic        mem_sel;
    logic [1:0]  mem_size;
    logic        pc_update;
    logic        load_ir;
    logic        load_mdr;
    logic        mem_wr_en;
    logic        reg_file_wr_en;
    logic        wr_reg_mux_sel;
    logic        op1_sel;
    logic [1:0]  op2_sel;
    logic [1:0]  alu_demux;
    logic [4:0]  alu_ctrl;
  } vec_t;

  typedef struct {
    string tag;
    vec_t  e;
    vec_t  m;
  } ent_t;

  vec_t obs;
  assign obs = {sz_ex_sel, sz_ex_mode, mem_sz_ex_sel, imm,
                mem_sel, mem_size, pc_update, load_ir,
                load_mdr, mem_wr_en, reg_file_wr_en,
                wr_reg_mux_sel, op1_sel, op2_sel,
                alu_demux, alu_ctrl};

  ent_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag,
                       input logic [42:0] got,
                       input logic [42:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  ent_t cur;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check(cur.tag, obs & cur.m, cur.e & cur.m);
    end
  end

  localparam vec_t ALL = '1;

  function automatic vec_t noimm();
    vec_t v = '1;
    v.imm        = '0;
    v.sz_ex_sel  = 1'b0;
    v.sz_ex_mode = 2'b00;
    return v;
  endfunction

  function automatic vec_t iv(input logic [19:0] im,
                              input logic s,
                              input logic [1:0] md);
    vec_t v = '0;
    v.imm        = im;
    v.sz_ex_sel  = s;
    v.sz_ex_mode = md;
    return v;
  endfunction

  function automatic vec_t fetch_v();
    vec_t v = '0;
    v.mem_size = 2'b10;
    v.load_ir  = 1'b1;
    return v;
  endfunction

  function automatic vec_t ex_v(input vec_t b, input logic op1,
                                input logic [1:0] op2,
                                input logic [1:0] dmx,
                                input logic [4:0] alu);
    vec_t v = b;
    v.op1_sel   = op1;
    v.op2_sel   = op2;
    v.alu_demux = dmx;
    v.alu_ctrl  = alu;
    return v;
  endfunction

  function automatic vec_t wb_v(input vec_t b, input logic op1,
                                input logic [1:0] op2,
                                input logic wr, input logic mx);
    vec_t v = b;
    v.pc_update      = 1'b1;
    v.alu_demux      = 2'b10;
    v.alu_ctrl       = 5'b00000;
    v.op1_sel        = op1;
    v.op2_sel        = op2;
    v.reg_file_wr_en = wr;
    v.wr_reg_mux_sel = mx;
    return v;
  endfunction

  task automatic cyc(input string tag, input vec_t e, input vec_t m);
    sb.push_back('{tag, e, m});
    @(posedge clk);
    #1;
  endtask

  vec_t b, v;

  initial begin
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc("rst", '0, ALL);
    rst = 1'b0;

    // illegal opcode: FETCH, DECODE, WB
    inst = 32'h0000_0034;
    cyc("ill_fetch", fetch_v(), ALL);
    cyc("ill_dec", '0, noimm());
    cyc("ill_wb", wb_v('0, 1'b1, 2'b10, 1'b0, 1'b0), noimm());

    // ADD x3,x1,x2
    inst = 32'h0020_81B3;
    cyc("add_fetch", fetch_v(), ALL);
    cyc("add_dec", '0, noimm());
    cyc("add_ex", ex_v('0, 1'b0, 2'b00, 2'b00, 5'b00000), noimm());
    cyc("add_wb", wb_v('0, 1'b1, 2'b10, 1'b1, 1'b0), noimm());

    // LW x2,4(x1)
    inst = 32'h0040_A103;
    b = iv(20'h00004, 1'b0, 2'b00);
    cyc("lw_fetch", fetch_v(), ALL);
    cyc("lw_dec", b, ALL);
    cyc("lw_ex", ex_v(b, 1'b0, 2'b01, 2'b01, 5'b00000), ALL);
    v = b;
    v.mem_sel = 1'b1; v.mem_size = 2'b10;
    v.load_mdr = 1'b1; v.mem_sz_ex_sel = 1'b1;
    cyc("lw_mem", v, ALL);
    cyc("lw_wb", wb_v(b, 1'b1, 2'b10, 1'b1, 1'b1), ALL);

    // SB x2,0(x1)
    inst = 32'h0020_8023;
    b = iv(20'h00000, 1'b0, 2'b00);
    cyc("sb_fetch", fetch_v(), ALL);
    cyc("sb_dec", b, ALL);
    cyc("sb_ex", ex_v(b, 1'b0, 2'b01, 2'b01, 5'b00000), ALL);
    v = b;
    v.mem_sel = 1'b1; v.mem_size = 2'b00; v.mem_wr_en = 1'b1;
    cyc("sb_mem", v, ALL);
    cyc("sb_wb", wb_v(b, 1'b1, 2'b10, 1'b0, 1'b0), ALL);

    // BEQ x1,x2,+8: taken then not taken; bcond only high in EXEC
    inst = 32'h0020_8463;
    b = iv(20'h00004, 1'b0, 2'b11);
    for (int t = 1; t >= 0; t--) begin
      cyc("beq_fetch", fetch_v(), ALL);
      cyc("beq_dec", b, ALL);
      bcond = t[0];
      cyc("beq_ex", ex_v(b, 1'b0, 2'b00, 2'b00, 5'b10000), ALL);
      bcond = 1'b0;
      cyc(t ? "beq_wb_taken" : "beq_wb_not",
          wb_v(b, 1'b1, t ? 2'b01 : 2'b10, 1'b0, 1'b0), ALL);
    end

    // SRAI x1,x2,3
    inst = 32'h4031_5093;
    b = iv(20'h00403, 1'b0, 2'b00);
    cyc("srai_fetch", fetch_v(), ALL);
    cyc("srai_dec", b, ALL);
    cyc("srai_ex", ex_v(b, 1'b0, 2'b01, 2'b00, 5'b01101), ALL);
    cyc("srai_wb", wb_v(b, 1'b1, 2'b10, 1'b1, 1'b0), ALL);

    // JAL x0,+8
    inst = 32'h0080_006F;
    b = iv(20'h00004, 1'b1, 2'b11);
    cyc("jal_fetch", fetch_v(), ALL);
    cyc("jal_dec", b, ALL);
    cyc("jal_ex", ex_v(b, 1'b1, 2'b10, 2'b00, 5'b00000), ALL);
    cyc("jal_wb", wb_v(b, 1'b1, 2'b01, 1'b1, 1'b0), ALL);

    // LUI x1,0x12345
    inst = 32'h1234_50B7;
    b = iv(20'h12345, 1'b1, 2'b10);
    cyc("lui_fetch", fetch_v(), ALL);
    cyc("lui_dec", b, ALL);
    cyc("lui_ex", ex_v(b, 1'b0, 2'b01, 2'b00, 5'b11111), ALL);
    cyc("lui_wb", wb_v(b, 1'b1, 2'b10, 1'b1, 1'b0), ALL);

    // LUI again with reset pulsed during EXEC
    cyc("luir_fetch", fetch_v(), ALL);
    cyc("luir_dec", b, ALL);
    rst = 1'b1;
    cyc("luir_rst", '0, ALL);
    rst = 1'b0;
    cyc("luir_refetch", fetch_v(), ALL);
    cyc("luir_dec2", b, ALL);

    check("sb_drained", 43'(sb.size()), 43'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
